// File: rtl/ps2_letter_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the bus, frames 11-bit
// PS/2 words, and decodes set-2 make/break codes for A..T into a 5-bit letter.
module ps2_letter_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbdclk,
  input  logic       kbddat,
  output logic [4:0] letter,
  output logic       letter_stb,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [4:0] LETTER_OTHER   = 5'd20;
  localparam logic [4:0] LETTER_RELEASE = 5'd21;

  // Valid/ready does not apply here: every event is a single-cycle pulse
  // with no back-pressure; a consumer must sample letter on letter_stb.
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e        state_q, state_d;
  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_q, fall_d;
  logic          bit_q, bit_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_hit;
  logic [4:0]    letter_q, letter_d;
  logic          stb_q, stb_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;

  function automatic logic [4:0] map_make(input logic [7:0] code);
    logic [4:0] r;
    case (code)
      8'h1C: r = 5'd0;   8'h32: r = 5'd1;   8'h21: r = 5'd2;   8'h23: r = 5'd3;
      8'h24: r = 5'd4;   8'h2B: r = 5'd5;   8'h34: r = 5'd6;   8'h33: r = 5'd7;
      8'h43: r = 5'd8;   8'h3B: r = 5'd9;   8'h42: r = 5'd10;  8'h4B: r = 5'd11;
      8'h3A: r = 5'd12;  8'h31: r = 5'd13;  8'h44: r = 5'd14;  8'h4D: r = 5'd15;
      8'h15: r = 5'd16;  8'h2D: r = 5'd17;  8'h1B: r = 5'd18;  8'h2C: r = 5'd19;
      default: r = LETTER_OTHER;
    endcase
    return r;
  endfunction

  // State register: every flop in the block, all reset to bus-idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
      bit_q      <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_ok_q   <= 1'b0;
      to_cnt_q   <= '0;
      letter_q   <= LETTER_OTHER;
      stb_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      fall_q     <= fall_d;
      bit_q      <= bit_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_ok_q   <= par_ok_d;
      to_cnt_q   <= to_cnt_d;
      letter_q   <= letter_d;
      stb_q      <= stb_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
    end
  end

  // Synchronizers and the kbdclk deglitch filter; the data bit is captured
  // in the same cycle the filtered clock is accepted as falling.
  always_comb begin
    clk_s1_d   = kbdclk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = kbddat;
    dat_s2_d   = dat_s1_q;
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fall_d     = 1'b0;
    bit_d      = bit_q;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = ~filt_q;
        if (filt_q) begin
          fall_d = 1'b1;
          bit_d  = dat_s2_q;
        end
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Next-state logic for the frame FSM, its datapath and the timeout.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    timeout_hit = (state_q != IDLE) && !fall_q && (to_cnt_q == TW'(TIMEOUT - 1));
    to_cnt_d    = '0;
    if (state_q != IDLE && !fall_q && !timeout_hit) to_cnt_d = to_cnt_q + 1'b1;
    case (state_q)
      IDLE: if (fall_q && !bit_q) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (fall_q) begin
        shift_d   = {bit_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall_q) begin
        par_ok_d = ^{shift_q, bit_q};
        state_d  = STOP;
      end
      STOP: if (fall_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout_hit) state_d = IDLE;
  end

  // Output logic: error pulses and the make/break decoder on a completed frame.
  always_comb begin
    letter_d = letter_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    stb_d    = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = timeout_hit;
    if (state_q == STOP && fall_q) begin
      if (!bit_q) begin
        ferr_d = 1'b1;
      end else if (!par_ok_q) begin
        perr_d = 1'b1;
      end else if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        letter_d = LETTER_RELEASE;
        brk_d    = 1'b0;
        ext_d    = 1'b0;
        stb_d    = 1'b1;
      end else if (ext_q) begin
        letter_d = LETTER_OTHER;
        ext_d    = 1'b0;
        stb_d    = 1'b1;
      end else begin
        letter_d = map_make(shift_q);
        stb_d    = 1'b1;
      end
    end
  end

  assign letter     = letter_q;
  assign letter_stb = stb_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_letter_rx.sv
// Self-checking bench for ps2_letter_rx: directed PS/2 scenarios plus random
// frames compared against a byte-level make/break reference model.
module tb_ps2_letter_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 200;
  localparam int HALF       = 20;
  // 2 synchronizer flops + FILTER_LEN filter samples + 1 cycle output latency.
  localparam int STB_LAT    = FILTER_LEN + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kbdclk = 1'b1;
  logic       kbddat = 1'b1;
  logic [4:0] letter;
  logic       letter_stb, parity_err, frame_err;

  ps2_letter_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .kbdclk(kbdclk), .kbddat(kbddat),
    .letter(letter), .letter_stb(letter_stb),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stb_cnt = 0, perr_cnt = 0, ferr_cnt = 0, overlap_cnt = 0;
  int last_stb_cyc = 0, last_fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (letter_stb) begin
      stb_cnt++;
      last_stb_cyc = cyc;
    end
    if (parity_err) perr_cnt++;
    if (frame_err) ferr_cnt++;
    if ((letter_stb && (parity_err || frame_err)) || (parity_err && frame_err))
      overlap_cnt++;
  end

  // Reference model state and the set-2 make codes for A..T.
  logic [7:0] codes [20] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                             8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                             8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C};
  int m_letter = 20;
  bit m_ext = 0, m_brk = 0;
  int e_stb, e_perr, e_ferr;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    kbddat = b;
    wait_cyc(HALF / 2);
    kbdclk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(HALF);
    kbdclk = 1'b1;
    wait_cyc(HALF / 2);
  endtask

  // Sends start + the first nbits-1 data bits, then leaves the bus idle.
  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits - 1; i++) send_bit(b[i]);
    kbddat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(!bad_stop);
    kbddat = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  function automatic void model(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int idx;
    e_stb = 0; e_perr = 0; e_ferr = 0;
    if (bad_stop) e_ferr = 1;
    else if (bad_par) e_perr = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (m_brk) begin
      m_letter = 21; m_brk = 0; m_ext = 0; e_stb = 1;
    end else if (m_ext) begin
      m_letter = 20; m_ext = 0; e_stb = 1;
    end else begin
      idx = 20;
      for (int i = 0; i < 20; i++) if (codes[i] == b) idx = i;
      m_letter = idx;
      e_stb = 1;
    end
  endfunction

  task automatic frame_and_check(input string tag, input logic [7:0] b,
                                 input bit bad_par, input bit bad_stop);
    int s0, p0, f0;
    s0 = stb_cnt; p0 = perr_cnt; f0 = ferr_cnt;
    model(b, bad_par, bad_stop);
    send_frame(b, bad_par, bad_stop);
    chk({tag, "_stb"}, stb_cnt - s0, e_stb);
    chk({tag, "_perr"}, perr_cnt - p0, e_perr);
    chk({tag, "_ferr"}, ferr_cnt - f0, e_ferr);
    chk({tag, "_letter"}, int'(letter), m_letter);
  endtask

  initial begin
    int s0, f0, p0;
    logic [7:0] b;
    int sel, err;

    // Reset state
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(2);
    chk("reset_letter", int'(letter), 20);
    chk("reset_stb", int'(letter_stb), 0);
    chk("reset_perr", int'(parity_err), 0);
    chk("reset_ferr", int'(frame_err), 0);

    // 0x1C -> A, with strobe latency measured from the stop-bit falling edge
    frame_and_check("make_1c", 8'h1C, 0, 0);
    chk("stb_latency", last_stb_cyc - last_fall_cyc, STB_LAT);

    // Break sequence F0 1C
    frame_and_check("brk_f0", 8'hF0, 0, 0);
    frame_and_check("brk_1c", 8'h1C, 0, 0);

    // Wrong parity on 0x2C
    frame_and_check("badpar_2c", 8'h2C, 1, 0);

    // Extended E0 75 then 2C
    frame_and_check("ext_e0", 8'hE0, 0, 0);
    frame_and_check("ext_75", 8'h75, 0, 0);
    frame_and_check("after_ext_2c", 8'h2C, 0, 0);

    // Repeat of the same make code still strobes
    frame_and_check("repeat_2c", 8'h2C, 0, 0);

    // Bad stop bit
    frame_and_check("badstop_32", 8'h32, 0, 1);

    // Truncated 0x15 frame times out, then a full 0x15
    s0 = stb_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    send_partial(8'h15, 4);
    wait_cyc(TIMEOUT + 40);
    chk("timeout_ferr", ferr_cnt - f0, 1);
    chk("timeout_stb", stb_cnt - s0, 0);
    chk("timeout_perr", perr_cnt - p0, 0);
    chk("timeout_letter", int'(letter), m_letter);
    frame_and_check("after_to_15", 8'h15, 0, 0);

    // Glitch of FILTER_LEN-1 cycles with data low must not start a frame
    f0 = ferr_cnt; s0 = stb_cnt;
    kbddat = 1'b0;
    wait_cyc(2);
    kbdclk = 1'b0;
    wait_cyc(FILTER_LEN - 1);
    kbdclk = 1'b1;
    wait_cyc(2);
    kbddat = 1'b1;
    wait_cyc(TIMEOUT + 40);
    chk("glitch_ferr", ferr_cnt - f0, 0);
    chk("glitch_stb", stb_cnt - s0, 0);

    // Reset mid-frame discards the partial frame and restores letter=20
    send_partial(8'h1C, 5);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    m_letter = 20; m_ext = 0; m_brk = 0;
    f0 = ferr_cnt; s0 = stb_cnt;
    wait_cyc(TIMEOUT + 40);
    chk("rst_letter", int'(letter), 20);
    chk("rst_idle_ferr", ferr_cnt - f0, 0);
    chk("rst_idle_stb", stb_cnt - s0, 0);
    frame_and_check("after_rst_2c", 8'h2C, 0, 0);

    // Random frames against the reference model
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) b = codes[$urandom_range(0, 19)];
      else if (sel == 5) b = 8'hE0;
      else if (sel == 6) b = 8'hF0;
      else b = 8'($urandom_range(0, 255));
      err = $urandom_range(0, 7);
      frame_and_check($sformatf("rnd%0d_%02h", n, b), b, err == 0, err == 1);
    end

    chk("no_overlap", overlap_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_letter_rx.md
PS2_LETTER_RX -- requirements
Module: ps2_letter_rx

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  FILTER_LEN, 8, consecutive equal synchronized kbdclk samples needed to accept a new level.
  TIMEOUT, 100000, clk cycles without an accepted kbdclk falling edge before a partial frame is discarded (1 ms at 100 MHz).
REQ-002 Ports SHALL be, one per line: name direction width meaning.
  clk  input  1  system clock; the block has one clock.
  rst  input  1  synchronous, active-high reset.
  kbdclk  input  1  PS/2 clock from the keyboard, asynchronous.
  kbddat  input  1  PS/2 data from the keyboard, asynchronous.
  letter  output  5  last decoded key code (held).
  letter_stb  output  1  one-cycle pulse when letter is written.
  parity_err  output  1  one-cycle pulse on an odd-parity failure.
  frame_err  output  1  one-cycle pulse on a bad stop bit or a timeout.

Function
REQ-003 kbdclk and kbddat SHALL each pass through a 2-flop synchronizer before any use.
REQ-004 The filtered PS/2 clock SHALL change level only after FILTER_LEN consecutive equal synchronized samples, and the data bit SHALL be sampled on its accepted 1->0 transition.
REQ-005 The receive FSM SHALL use the states IDLE, DATA, PARITY and STOP.
REQ-006 IDLE: a sampled 0 SHALL move the FSM to DATA with the bit count at 0, and a sampled 1 SHALL be ignored.
REQ-007 DATA: the FSM SHALL shift in 8 bits LSB first, then move to PARITY.
REQ-008 PARITY: the FSM SHALL accept the frame only if the 8 data bits plus the parity bit contain an odd number of ones; otherwise it SHALL pulse parity_err after the stop bit and discard the byte.
REQ-009 STOP: a sampled 1 SHALL deliver the byte to the decoder; a sampled 0 SHALL pulse frame_err and discard the byte; either case SHALL return the FSM to IDLE.
REQ-010 In any state other than IDLE, TIMEOUT clk cycles with no accepted falling edge SHALL pulse frame_err and return the FSM to IDLE, discarding partial data.
REQ-011 Decoder byte 0xE0 SHALL set the ext flag and produce no output.
REQ-012 Decoder byte 0xF0 SHALL set the brk flag and produce no output.
REQ-013 Any other byte with brk=1 SHALL write letter=21 and clear both brk and ext.
REQ-014 Any other byte with brk=0 and ext=0 SHALL write letter as follows: set-2 make codes A..T (1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C) map to 0..19, and every other byte maps to 20.
REQ-015 Any other byte with ext=1 and brk=0 SHALL write letter=20 and clear ext.
REQ-016 Codes 22..31 SHALL never be produced.
REQ-017 letter and letter_stb SHALL update on the clk edge after the accepted falling edge that samples a good stop bit (1-cycle latency), and letter SHALL hold its value until the next write.
REQ-018 A write of a value equal to the current letter SHALL still pulse letter_stb.
REQ-019 Bytes discarded for a parity or frame error SHALL leave letter, ext and brk unchanged.
REQ-020 A keyboard auto-repeat make code SHALL be decoded exactly like a first press.
REQ-021 parity_err and frame_err SHALL never pulse in the same cycle as each other.
REQ-022 letter_stb SHALL never pulse in the same cycle as parity_err or frame_err.

Reset
REQ-023 When rst=1 at a clk edge, the block SHALL take the reset values below, overriding any other event in that cycle.
  letter=20; letter_stb=0; parity_err=0; frame_err=0.
  FSM=IDLE; bit count=0; ext=0; brk=0; timeout counter=0.
  Synchronizers and the filtered clock reset to 1 (bus idle level).
REQ-024 rst asserted mid-frame SHALL discard the partial frame, and reception SHALL restart only at the next start bit seen after rst deasserts.
REQ-025 letter SHALL NOT be reset to 21, so that a downstream stage waiting for the release code does not trigger on reset.

Verification
REQ-026 The bench SHALL cover these directed scenarios.
  Frame 0x1C with good parity -> letter=0 and one letter_stb, 1 cycle after the stop edge.
  Frames F0 then 1C -> no strobe after F0; after 1C, letter=21 with one strobe.
  Frame 0x2C with a wrong parity bit -> one parity_err pulse, letter unchanged, no strobe.
  Frames E0 then 75, then 2C -> letter=20 with ext cleared, then letter=19.
  Frame 0x15 stopped after 4 bits for TIMEOUT+1 cycles, then a full 0x15 frame -> one frame_err pulse, then letter=16.
  kbdclk glitch of FILTER_LEN-1 cycles low while IDLE, with rst asserted mid-frame afterwards -> no bit accepted from the glitch; after rst, letter=20 and the FSM is in IDLE.
